ca_gen_scheduler: RTL and testbench
===================================

Name: ca_gen_scheduler

Overview:
- Sequences cellular-automaton generation updates on the DE1-SoC.
- Decides when a new generation is computed: single-step from a key, or free-run at a selectable rate.
- Handshakes each update with the CA cell array.
- Drives the count/clear inputs of the 4-bit generation counter, and reads its value back for the limit check.

Parameters:
- DIV_BASE, 25_000_000, base tick period in clk cycles (period = DIV_BASE << rate_sel); benches override to 4.
- DIV_W, 32, prescaler width; must hold (DIV_BASE << 3) - 1.
- GEN_W, 4, generation counter width.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- run  input  1  level; 1 = free-run mode.
- step  input  1  one-cycle pulse (already debounced/edge-detected); request a single generation.
- clear  input  1  one-cycle pulse; zero the generation counter.
- rate_sel  input  2  run speed; period = DIV_BASE << rate_sel cycles.
- update_ack  input  1  CA array has finished the requested generation.
- cnt_val  input  GEN_W  current generation counter value.
- update_req  output  1  request CA array to compute the next generation.
- cnt_en  output  1  one-cycle increment pulse to the counter's count input.
- cnt_clr  output  1  one-cycle clear pulse to the counter's reset input.
- busy  output  1  update in flight.
- done  output  1  generation limit reached (see Optional Feature).

Behaviour:
- Reset (reset=0, async): state=IDLE, prescaler=0, clr_pend=0; all outputs 0.
- All outputs are decoded from registered state/flags, so none is combinational from an input.
- States:
  - IDLE: step=1 -> REQ. Else run=1 -> ARMED with prescaler=0. Step has priority over run when both are high.
  - ARMED: prescaler increments each cycle. At (DIV_BASE<<rate_sel)-1 -> REQ, prescaler=0. run=0 -> IDLE, prescaler=0. step ignored.
  - rate_sel is sampled every cycle. If a change makes prescaler >= the new terminal count, the next cycle fires REQ.
  - REQ: update_req=1, busy=1. Held until update_ack=1 is sampled -> COMMIT. run/step changes do not abort. Steps arriving in REQ are dropped.
  - COMMIT: cnt_en=1 and busy=1 for exactly one cycle. Next state: ARMED if run=1, else IDLE.
- Latency: step sampled at edge k -> update_req high in cycle k+1. If ack arrives in k+1, cnt_en is high in cycle k+2 and the counter increments at the end of k+2. Minimum 2 cycles from step to count.
- update_ack outside REQ is ignored.
- clear:
  - In IDLE/ARMED: cnt_clr=1 in the next cycle; prescaler reset to 0.
  - In REQ/COMMIT: set clr_pend. cnt_clr pulses in the cycle after COMMIT, then clr_pend clears.
  - cnt_en and cnt_clr are never high in the same cycle.
- Counter wrap (15 -> 0) belongs to the counter; without the optional feature the scheduler is unaware of it.
- Reset mid-handshake returns to IDLE immediately and drops update_req. The CA array must tolerate an abandoned request.

Optional Feature:
- GEN_LIMIT_EN defined:
  - When cnt_val == all-ones (15) in IDLE/ARMED, done=1.
  - ARMED stops issuing REQ (prescaler frozen), and step in IDLE is ignored.
  - clear releases it: done=0 once cnt_val != 15.
  - An update already in REQ completes normally.
- GEN_LIMIT_EN undefined: done tied to 0; counting wraps freely.

Decomposition:
- Package ca_pkg holds:
  - typedef enum logic [1:0] {IDLE, ARMED, REQ, COMMIT} sched_state_t;
  - localparam GEN_MAX = 4'hF.
- One sub-module, ca_rate_prescaler: counter, terminal-count compare, clear/enable inputs, one-cycle tick output.

Test Plan (DIV_BASE=4):
1. Reset low 2 cycles, then high; step pulse; ack in the first REQ cycle -> update_req high 1 cycle after step, cnt_en high 1 cycle after that, busy high both cycles.
2. run=1, rate_sel=0, ack immediate -> update_req every 6 cycles (4 prescaler + REQ + COMMIT); rate_sel=2 -> every 18.
3. step, ack delayed 5 cycles -> update_req held 6 cycles, cnt_en single pulse; second step during REQ dropped (one cnt_en total).
4. clear during REQ -> no cnt_clr until after COMMIT; cnt_clr pulses the cycle after cnt_en, never overlapping it.
5. reset asserted while update_req=1 -> update_req, busy, cnt_en drop to 0 asynchronously; state IDLE after release.
6. GEN_LIMIT_EN, run=1, cnt_val=15 -> done=1, no further update_req for 40 cycles; clear with cnt_val returning to 0 -> done=0 and updates resume.

Source files
------------

// File: rtl/ca_pkg.sv
// Shared types and constants for the cellular-automaton generation scheduler.
package ca_pkg;

    typedef enum logic [1:0] {IDLE, ARMED, REQ, COMMIT} sched_state_t;

    localparam logic [3:0] GEN_MAX = 4'hF;

endpackage

// File: rtl/ca_rate_prescaler.sv
// Free-run rate prescaler: counts while enabled and emits a one-cycle tick at
// the terminal count (DIV_BASE << rate_sel) - 1, then restarts from zero.
module ca_rate_prescaler #(
    parameter int DIV_BASE = 25_000_000,
    parameter int DIV_W    = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    input  logic [1:0] rate_sel,
    output logic       tick
);

    logic [DIV_W-1:0] count_reg;
    logic [DIV_W-1:0] term_cnt;

    assign term_cnt = (DIV_W'(DIV_BASE) << rate_sel) - DIV_W'(1);

    // >= rather than == so a rate change that lands below the count fires at once
    assign tick = en && (count_reg >= term_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr || tick) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + DIV_W'(1);
        end
    end

endmodule

// File: rtl/ca_gen_scheduler.sv
// Generation scheduler: single-step or free-run update handshake with the CA
// array and count/clear pulses for the generation counter. GEN_LIMIT_EN adds a stop at 15.
module ca_gen_scheduler
    import ca_pkg::*;
#(
    parameter int DIV_BASE = 25_000_000,
    parameter int DIV_W    = 32,
    parameter int GEN_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic             clear,
    input  logic [1:0]       rate_sel,
    input  logic             update_ack,
    input  logic [GEN_W-1:0] cnt_val,
    output logic             update_req,
    output logic             cnt_en,
    output logic             cnt_clr,
    output logic             busy,
    output logic             done
);

`ifdef GEN_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    sched_state_t state_reg, state_next;
    logic clr_pend_reg, clr_pend_next;
    logic update_req_reg, cnt_en_reg, cnt_clr_reg, busy_reg, done_reg;

    logic at_limit;
    logic idle_or_armed;
    logic presc_en, presc_clr, presc_tick;
    logic clr_fire;

    assign at_limit      = LIMIT_EN && (cnt_val == GEN_W'(GEN_MAX));
    assign idle_or_armed = (state_reg == IDLE) || (state_reg == ARMED);

    // The prescaler only runs in ARMED; leaving ARMED leaves it at zero for the next entry
    assign presc_en  = (state_reg == ARMED) && !at_limit;
    assign presc_clr = (state_reg != ARMED) || clear;

    ca_rate_prescaler #(
        .DIV_BASE (DIV_BASE),
        .DIV_W    (DIV_W)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (reset),
        .en       (presc_en),
        .clr      (presc_clr),
        .rate_sel (rate_sel),
        .tick     (presc_tick)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (step && !at_limit) state_next = REQ;
                else if (run)          state_next = ARMED;
            end
            ARMED: begin
                if (!run)            state_next = IDLE;
                else if (presc_tick) state_next = REQ;
            end
            REQ: begin
                if (update_ack) state_next = COMMIT;
            end
            COMMIT: begin
                state_next = run ? ARMED : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A clear that lands mid-handshake is deferred so it never collides with cnt_en
    assign clr_fire = (idle_or_armed && clear) ||
                      ((state_reg == COMMIT) && (clr_pend_reg || clear));

    always_comb begin
        clr_pend_next = clr_pend_reg;
        if (state_reg == COMMIT)            clr_pend_next = 1'b0;
        else if (state_reg == REQ && clear) clr_pend_next = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            clr_pend_reg   <= 1'b0;
            update_req_reg <= 1'b0;
            cnt_en_reg     <= 1'b0;
            cnt_clr_reg    <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            clr_pend_reg   <= clr_pend_next;
            update_req_reg <= (state_next == REQ);
            cnt_en_reg     <= (state_next == COMMIT);
            cnt_clr_reg    <= clr_fire;
            busy_reg       <= (state_next == REQ) || (state_next == COMMIT);
            done_reg       <= at_limit && ((state_next == IDLE) || (state_next == ARMED));
        end
    end

    assign update_req = update_req_reg;
    assign cnt_en     = cnt_en_reg;
    assign cnt_clr    = cnt_clr_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_ca_gen_scheduler.sv
// Self-checking bench for ca_gen_scheduler with DIV_BASE=4; models the external
// 4-bit generation counter and predicts timing from the scheduling rules.
module tb_ca_gen_scheduler;

    localparam int DIV_BASE = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic       step;
    logic       clear;
    logic [1:0] rate_sel;
    logic       update_ack;
    logic [3:0] cnt_val = 4'd0;
    logic       update_req;
    logic       cnt_en;
    logic       cnt_clr;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int exp_gen = 0;
    int overlap = 0;

    ca_gen_scheduler #(
        .DIV_BASE (DIV_BASE),
        .DIV_W    (32),
        .GEN_W    (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .step       (step),
        .clear      (clear),
        .rate_sel   (rate_sel),
        .update_ack (update_ack),
        .cnt_val    (cnt_val),
        .update_req (update_req),
        .cnt_en     (cnt_en),
        .cnt_clr    (cnt_clr),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // External generation counter as it sits on the board
    always @(posedge clk) begin
        if (cnt_clr)     cnt_val <= 4'd0;
        else if (cnt_en) cnt_val <= cnt_val + 4'd1;
        if (cnt_en && cnt_clr) overlap <= overlap + 1;
    end

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Single step; ack after d extra REQ cycles; a second step is pulsed inside REQ and must be dropped
    task automatic single_step(input int d);
        step = 1'b1;
        tick();
        step = 1'b0;
        for (int i = 0; i <= d; i++) begin
            chk("step_req_held", update_req, 1);
            chk("step_busy_req", busy, 1);
            chk("step_no_en_in_req", cnt_en, 0);
            step = (i == 1);
            if (i == d) update_ack = 1'b1;
            tick();
        end
        update_ack = 1'b0;
        step = 1'b0;
        chk("step_cnt_en", cnt_en, 1);
        chk("step_req_dropped", update_req, 0);
        chk("step_busy_commit", busy, 1);
        exp_gen = (exp_gen + 1) % 16;
        tick();
        chk("step_en_single", cnt_en, 0);
        chk("step_idle_busy", busy, 0);
        chk("step_idle_req", update_req, 0);
        chk("step_count", cnt_val, exp_gen);
        $display("step: ack_delay=%0d gen=%0d", d, cnt_val);
    endtask

    // Free-run at rate r; REQ-to-REQ spacing must be (DIV_BASE<<r) + d + 2
    task automatic free_run(input int r, input int d, input int n);
        int t_prev;
        int waited;
        t_prev = 0;
        rate_sel = 2'(r);
        run = 1'b1;
        for (int k = 0; k < n; k++) begin
            waited = 0;
            while (!update_req && waited < 200) begin
                tick();
                waited++;
            end
            chk("run_req_timeout", 32'(waited < 200), 1);
            if (k > 0) chk("run_period", cyc - t_prev, (DIV_BASE << r) + d + 2);
            $display("run: rate=%0d ack_delay=%0d req_at=%0d spacing=%0d", r, d, cyc, cyc - t_prev);
            t_prev = cyc;
            for (int i = 0; i < d; i++) begin
                tick();
                chk("run_req_held", update_req, 1);
            end
            update_ack = 1'b1;
            tick();
            update_ack = 1'b0;
            chk("run_cnt_en", cnt_en, 1);
            exp_gen = (exp_gen + 1) % 16;
            tick();
            chk("run_en_single", cnt_en, 0);
            chk("run_count", cnt_val, exp_gen);
        end
        run = 1'b0;
        tick();
        chk("run_stop_busy", busy, 0);
        tick();
        chk("run_stop_req", update_req, 0);
    endtask

    task automatic clear_idle();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_idle_pulse", cnt_clr, 1);
        tick();
        chk("clr_idle_single", cnt_clr, 0);
        chk("clr_idle_count", cnt_val, 0);
        exp_gen = 0;
        $display("clear: gen=%0d", cnt_val);
    endtask

    initial begin
        int n_req;
        reset = 1'b0;
        run = 1'b0;
        step = 1'b0;
        clear = 1'b0;
        rate_sel = 2'd0;
        update_ack = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_update_req", update_req, 0);
        chk("rst_cnt_en", cnt_en, 0);
        chk("rst_cnt_clr", cnt_clr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1'b1;
        tick();
        clear_idle();

        // Minimum latency, then long ack with a dropped second step
        single_step(0);
        single_step(5);

        // Free run at rates 0 and 2
        free_run(0, 0, 3);
        free_run(2, 0, 3);

        // Lowering the rate mid-count fires REQ on the next cycle
        rate_sel = 2'd2;
        run = 1'b1;
        repeat (10) tick();
        chk("rate_chg_no_req_yet", update_req, 0);
        rate_sel = 2'd0;
        tick();
        chk("rate_chg_req", update_req, 1);
        update_ack = 1'b1;
        tick();
        update_ack = 1'b0;
        run = 1'b0;
        chk("rate_chg_cnt_en", cnt_en, 1);
        exp_gen = (exp_gen + 1) % 16;
        tick();
        tick();
        chk("rate_chg_idle", busy, 0);
        $display("rate change: gen=%0d", cnt_val);

        // Clear during REQ is held off until after COMMIT
        step = 1'b1;
        tick();
        step = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_req_no_pulse", cnt_clr, 0);
        chk("clr_req_still_req", update_req, 1);
        update_ack = 1'b1;
        tick();
        update_ack = 1'b0;
        chk("clr_commit_en", cnt_en, 1);
        chk("clr_commit_no_clr", cnt_clr, 0);
        tick();
        chk("clr_after_commit", cnt_clr, 1);
        chk("clr_after_no_en", cnt_en, 0);
        tick();
        chk("clr_single", cnt_clr, 0);
        chk("clr_count_zero", cnt_val, 0);
        exp_gen = 0;
        $display("deferred clear: gen=%0d", cnt_val);

        // Asynchronous reset while a request is outstanding
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("arst_req_before", update_req, 1);
        #2 reset = 1'b0;
        #1;
        chk("arst_req_drop", update_req, 0);
        chk("arst_busy_drop", busy, 0);
        chk("arst_en_drop", cnt_en, 0);
        tick();
        reset = 1'b1;
        tick();
        chk("arst_idle_req", update_req, 0);
        chk("arst_idle_busy", busy, 0);
        $display("async reset mid-handshake: req=%0d busy=%0d", update_req, busy);
        single_step(1);

        // Randomized mix
        for (int t = 0; t < 12; t++) begin
            case ($urandom_range(0, 2))
                0: single_step(int'($urandom_range(0, 6)));
                1: free_run(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 3);
                default: clear_idle();
            endcase
        end

        // Generation limit at 15
        while (exp_gen != 15) single_step(0);
        tick();
        tick();
`ifdef GEN_LIMIT_EN
        chk("limit_done", done, 1);
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("limit_step_ignored", update_req, 0);
        tick();
`else
        chk("nolimit_done", done, 0);
`endif
        n_req = 0;
        run = 1'b1;
        rate_sel = 2'd0;
        update_ack = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (update_req) n_req++;
        end
`ifdef GEN_LIMIT_EN
        chk("limit_no_req", n_req, 0);
        chk("limit_done_hold", done, 1);
`else
        chk("nolimit_reqs", 32'(n_req > 0), 1);
        chk("nolimit_done_hold", done, 0);
`endif
        $display("limit window: requests=%0d done=%0d", n_req, done);
        run = 1'b0;
        repeat (3) tick();
        update_ack = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("limit_clr_pulse", cnt_clr, 1);
        tick();
        tick();
        chk("limit_released", done, 0);
        chk("limit_cnt_zero", cnt_val, 0);
        exp_gen = 0;
        single_step(0);

        chk("no_en_clr_overlap", overlap, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
